// File: rtl/udivision_iter_frac.sv
// udivision_iter_frac
// Sequential unsigned fractional divider: quotient = numerator / denominator
// as a 0.F fraction with N_BITS_OUT bits, one restoring step per clock.
//
// Optional feature macro: UDIV_ROUND_EN
//   defined   -> one extra guard step, round half up, clamp on overflow
//   undefined -> truncation only
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   numerator           dividend, N_BITS_IN bits
//   denominator         divisor,  N_BITS_IN bits
//   out_valid/out_ready result handshake (result held until accepted)
//   quotient            min(floor(num*2^N_BITS_OUT/den), 2^N_BITS_OUT-1)
//   div_by_zero         result came from denominator == 0
//   saturated           true quotient >= 1.0 (or rounding overflow), clamped
module udivision_iter_frac #(
    parameter int N_BITS_IN  = 8,
    parameter int N_BITS_OUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS_IN-1:0]  numerator,
    input  logic [N_BITS_IN-1:0]  denominator,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_BITS_OUT-1:0] quotient,
    output logic                  div_by_zero,
    output logic                  saturated
);

`ifdef UDIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif
    // Quotient shift register holds the result bits plus the optional guard bit.
    localparam int QW    = N_BITS_OUT + GUARD;
    localparam int CNT_W = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [N_BITS_IN:0]    rem_r, rem_s;
    logic [N_BITS_IN-1:0]  den_r, den_s;
    logic [QW-1:0]         quo_r, quo_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  dz_pend_r, dz_pend_s;
    logic                  sat_pend_r, sat_pend_s;
    logic                  out_valid_r, out_valid_s;
    logic [N_BITS_OUT-1:0] quotient_r, quotient_s;
    logic                  div_by_zero_r, div_by_zero_s;
    logic                  saturated_r, saturated_s;
    logic [N_BITS_IN:0]    r2_s;
    logic [N_BITS_IN:0]    diff_s;
    logic                  ge_s;

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign div_by_zero = div_by_zero_r;
    assign saturated   = saturated_r;

    // Next-state, datapath step and output register inputs.
    always_comb begin
        state_s       = state_r;
        rem_s         = rem_r;
        den_s         = den_r;
        quo_s         = quo_r;
        cnt_s         = cnt_r;
        dz_pend_s     = dz_pend_r;
        sat_pend_s    = sat_pend_r;
        out_valid_s   = out_valid_r;
        quotient_s    = quotient_r;
        div_by_zero_s = div_by_zero_r;
        saturated_s   = saturated_r;

        // Restoring step; R < den keeps R<<1 within N_BITS_IN+1 bits.
        r2_s   = {rem_r[N_BITS_IN-1:0], 1'b0};
        ge_s   = (r2_s >= {1'b0, den_r});
        diff_s = r2_s - {1'b0, den_r};

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    den_s      = denominator;
                    quo_s      = {QW{1'b0}};
                    dz_pend_s  = (denominator == {N_BITS_IN{1'b0}});
                    sat_pend_s = (denominator != {N_BITS_IN{1'b0}}) && (numerator >= denominator);
                    state_s    = CALC;
                    // Shortcut cases skip the steps (counter 0) but still spend
                    // one finalize cycle, giving them a one-cycle latency.
                    if ((denominator == {N_BITS_IN{1'b0}}) || (numerator >= denominator)) begin
                        rem_s = {(N_BITS_IN+1){1'b0}};
                        cnt_s = {CNT_W{1'b0}};
                    end else begin
                        rem_s = {1'b0, numerator};
                        cnt_s = CNT_W'(QW);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    quo_s = {quo_r[QW-2:0], ge_s};
                    rem_s = ge_s ? diff_s : r2_s;
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    // Finalize: the result registers load from the completed
                    // shift register, keeping rounding off the step path.
                    state_s       = DONE;
                    out_valid_s   = 1'b1;
                    div_by_zero_s = 1'b0;
                    saturated_s   = 1'b0;
                    if (dz_pend_r) begin
                        quotient_s    = {N_BITS_OUT{1'b1}};
                        div_by_zero_s = 1'b1;
                    end else if (sat_pend_r) begin
                        quotient_s  = {N_BITS_OUT{1'b1}};
                        saturated_s = 1'b1;
                    end else begin
`ifdef UDIV_ROUND_EN
                        if (quo_r[0]) begin
                            if (&quo_r[QW-1:1]) begin
                                quotient_s  = {N_BITS_OUT{1'b1}};
                                saturated_s = 1'b1;
                            end else begin
                                quotient_s = quo_r[QW-1:1] + {{(N_BITS_OUT-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            quotient_s = quo_r[QW-1:1];
                        end
`else
                        quotient_s = quo_r;
`endif
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            rem_r         <= {(N_BITS_IN+1){1'b0}};
            den_r         <= {N_BITS_IN{1'b0}};
            quo_r         <= {QW{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            dz_pend_r     <= 1'b0;
            sat_pend_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            quotient_r    <= {N_BITS_OUT{1'b0}};
            div_by_zero_r <= 1'b0;
            saturated_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            rem_r         <= rem_s;
            den_r         <= den_s;
            quo_r         <= quo_s;
            cnt_r         <= cnt_s;
            dz_pend_r     <= dz_pend_s;
            sat_pend_r    <= sat_pend_s;
            out_valid_r   <= out_valid_s;
            quotient_r    <= quotient_s;
            div_by_zero_r <= div_by_zero_s;
            saturated_r   <= saturated_s;
        end
    end

endmodule

// File: tb/tb_udivision_iter_frac.sv
module tb_udivision_iter_frac;

`ifdef UDIV_ROUND_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int LIMIT = 40;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] numerator;
    logic [7:0] denominator;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic       div_by_zero;
    logic       saturated;

    int total = 0;
    int bad   = 0;

    // Expected results packed as {div_by_zero, saturated, quotient}.
    logic [9:0] exp_q[$];

    udivision_iter_frac #(.N_BITS_IN(8), .N_BITS_OUT(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .numerator(numerator), .denominator(denominator),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .div_by_zero(div_by_zero), .saturated(saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] model(input logic [7:0] n, input logic [7:0] d);
        int t;
        logic [7:0] q;
        if (d == 8'd0) return {2'b10, 8'hFF};
        if (n >= d) return {2'b01, 8'hFF};
        t = (int'(n) << (8 + G)) / int'(d);
        if (G == 1) begin
            q = 8'(t >> 1);
            if ((t % 2) == 1) begin
                if (q == 8'hFF) return {2'b01, 8'hFF};
                q = q + 8'd1;
            end
            return {2'b00, q};
        end
        return {2'b00, 8'(t)};
    endfunction

    function automatic int exp_latency(input logic [7:0] n, input logic [7:0] d);
        if (d == 8'd0 || n >= d) return 1;
        return 9 + G;
    endfunction

    // Drives one operation, pushes its expected result, waits (bounded) for
    // the result, optionally stalls out_ready, then completes the handshake.
    task automatic run_op(input logic [7:0] n, input logic [7:0] d, input logic [9:0] expv,
                          input int stall, output logic [9:0] obs, output int lat,
                          output bit held);
        numerator   = n;
        denominator = d;
        in_valid    = 1'b1;
        out_ready   = (stall == 0);
        exp_q.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        obs  = {div_by_zero, saturated, quotient};
        held = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || {div_by_zero, saturated, quotient} !== obs || in_ready !== 1'b0)
                held = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        numerator = 8'd0; denominator = 8'd0;
        #12;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if ({div_by_zero, saturated, quotient} !== 10'h000)
            begin bad++; $display("FAIL reset_outputs got=%h want=000", {div_by_zero, saturated, quotient}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] tn[6];
        logic [7:0] td[6];
        logic [9:0] te[6];
        logic [9:0] obs, expv;
        int lat;
        bit held;
        tn = '{8'd1, 8'd2, 8'd254, 8'd0, 8'd5, 8'd7};
        td = '{8'd3, 8'd3, 8'd255, 8'd9, 8'd0, 8'd7};
        te[0] = 10'h055;
        te[1] = (G == 1) ? 10'h0AB : 10'h0AA;
        te[2] = (G == 1) ? 10'h0FF : 10'h0FE;
        te[3] = 10'h000;
        te[4] = 10'h2FF;
        te[5] = 10'h1FF;
        for (int i = 0; i < 6; i++) begin
            run_op(tn[i], td[i], te[i], (i % 2) * 2, obs, lat, held);
            expv = exp_q.pop_front();
            total++; if (obs !== expv)
                begin bad++; $display("FAIL basic_result %0d/%0d got=%h want=%h", tn[i], td[i], obs, expv); end
            total++; if (lat !== exp_latency(tn[i], td[i]))
                begin bad++; $display("FAIL basic_latency %0d/%0d got=%0d want=%0d", tn[i], td[i], lat, exp_latency(tn[i], td[i])); end
            total++; if (held !== 1'b1)
                begin bad++; $display("FAIL basic_hold %0d/%0d got=%b want=1", tn[i], td[i], held); end
        end
    endtask

    task automatic test_stall;
        logic [9:0] expv;
        int w;
        numerator = 8'd1; denominator = 8'd3; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(10'h055);
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < LIMIT) begin @(posedge clk); #1; w++; end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_timeout got=%b want=1", out_valid); end
        expv = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; numerator = 8'($urandom_range(0, 255)); denominator = 8'd0;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b want=1", out_valid); end
            total++; if ({div_by_zero, saturated, quotient} !== expv)
                begin bad++; $display("FAIL stall_result got=%h want=%h", {div_by_zero, saturated, quotient}, expv); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release_out_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_ghost got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] obs, expv;
        int lat;
        bit held;
        numerator = 8'd1; denominator = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if ({div_by_zero, saturated, quotient} !== 10'h000)
            begin bad++; $display("FAIL midrst_outputs got=%h want=000", {div_by_zero, saturated, quotient}); end
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%b want=0", out_valid); end
        run_op(8'd1, 8'd3, 10'h055, 0, obs, lat, held);
        expv = exp_q.pop_front();
        total++; if (obs !== expv) begin bad++; $display("FAIL midrst_result got=%h want=%h", obs, expv); end
        total++; if (lat !== 9 + G) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, 9 + G); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] n, d;
        logic [9:0] obs, expv;
        int lat, nres;
        bit held;
        nres = 0;
        for (int i = 0; i < 200; i++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) n = 8'($urandom_range(0, 255));
            else n = (d == 8'd0) ? 8'd0 : 8'($urandom_range(0, int'(d) - 1));
            run_op(n, d, model(n, d), $urandom_range(0, 3), obs, lat, held);
            if (lat < LIMIT) nres++;
            expv = exp_q.pop_front();
            total++; if (obs !== expv)
                begin bad++; $display("FAIL b2b_result %0d/%0d got=%h want=%h", n, d, obs, expv); end
            total++; if (lat !== exp_latency(n, d))
                begin bad++; $display("FAIL b2b_latency %0d/%0d got=%0d want=%0d", n, d, lat, exp_latency(n, d)); end
            total++; if (held !== 1'b1)
                begin bad++; $display("FAIL b2b_hold %0d/%0d got=%b want=1", n, d, held); end
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin bad++; $display("FAIL b2b_after_hs got=%b%b want=01", out_valid, in_ready); end
        end
        total++; if (nres !== 200) begin bad++; $display("FAIL b2b_count got=%0d want=200", nres); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_queue got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
